// File: rtl/display_pkg.sv
// Shared types and helpers for the seven-segment display scanner.
package display_pkg;

   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } scan_state_t;

   localparam int DIGIT_W    = 4;
   localparam int MAX_DIGITS = 8;

   // Active-low one-hot anode pattern; callers truncate to their digit count.
   function automatic logic [MAX_DIGITS-1:0] digit_sel(input logic [2:0] idx);
      return ~(MAX_DIGITS'(1) << idx);
   endfunction

endpackage

// File: rtl/slot_timer.sv
// Per-slot prescaler: counts 0..PRESCALE-1 and flags the last cycle of the slot.
module slot_timer #(
   parameter int PRESCALE = 1000,
   parameter int CNT_W    = $clog2(PRESCALE)
) (
   input  logic             clk,
   input  logic             rst,
   output logic [CNT_W-1:0] cnt,
   output logic             slot_end
);

   assign slot_end = (cnt == CNT_W'(PRESCALE - 1));

   always_ff @(posedge clk) begin
      if (rst || slot_end) cnt <= '0;
      else                 cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed common-anode seven-segment scanner with a frame-synchronous
// double buffer between the load port and the displayed digits.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   BLANK | first BLANK_CYCLES of a slot, all anodes off, code presented
//   SHOW  | remainder of the slot, anode of the current digit driven low
module display_scanner
   import display_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int PRESCALE     = 1000,
   parameter int BLANK_CYCLES = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          load,
   input  logic [DIGIT_W*NUM_DIGITS-1:0] din,
   output logic [DIGIT_W-1:0]            digit_out,
   output logic [NUM_DIGITS-1:0]         anode_n,
   output logic                          frame_done
);

   localparam int CNT_W = $clog2(PRESCALE);
   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam int WORD_W = DIGIT_W * NUM_DIGITS;

   logic [CNT_W-1:0]  cnt;
   logic              slot_end;
   logic [IDX_W-1:0]  index, idx_nxt;
   logic [WORD_W-1:0] shadow, active, active_nxt;
   logic              pending, frame_wrap;
   scan_state_t       state;

   slot_timer #(.PRESCALE(PRESCALE), .CNT_W(CNT_W)) u_slot_timer (
      .clk      (clk),
      .rst      (rst),
      .cnt      (cnt),
      .slot_end (slot_end)
   );

   // Outputs are registered one cycle ahead, so they are computed from the
   // values index/active will take after this edge.
   always_comb begin
      idx_nxt    = index;
      frame_wrap = 1'b0;
      if (slot_end) begin
         if (index == IDX_W'(NUM_DIGITS - 1)) begin
            idx_nxt    = '0;
            frame_wrap = 1'b1;
         end else begin
            idx_nxt = index + 1'b1;
         end
      end
      active_nxt = (frame_wrap && pending) ? shadow : active;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shadow     <= '0;
         active     <= '0;
         pending    <= 1'b0;
         index      <= '0;
         state      <= BLANK;
         anode_n    <= '1;
         digit_out  <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= frame_wrap;

         case (state)
            BLANK: if (cnt == CNT_W'(BLANK_CYCLES - 1)) begin
               state   <= SHOW;
               anode_n <= NUM_DIGITS'(digit_sel(3'(index)));
            end
            SHOW: if (slot_end) begin
               state   <= BLANK;
               anode_n <= '1;
            end
            default: state <= BLANK;
         endcase

         if (slot_end) begin
            index     <= idx_nxt;
            active    <= active_nxt;
            digit_out <= active_nxt[idx_nxt*DIGIT_W +: DIGIT_W];
         end

         // A load on the boundary edge must survive the transfer, so it wins.
         if (frame_wrap) pending <= 1'b0;
         if (load) begin
            shadow  <= din;
            pending <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_display_scanner.sv
// Self-checking bench for display_scanner: directed plan steps plus random loads
// against a cycle-indexed frame/slot model.
module tb_display_scanner;

   localparam int N  = 4;
   localparam int P  = 6;
   localparam int B  = 2;
   localparam int NP = N * P;

   logic          clk = 1'b0;
   logic          rst;
   logic          load;
   logic [15:0]   din;
   logic [3:0]    digit_out;
   logic [N-1:0]  anode_n;
   logic          frame_done;

   int errors = 0;
   int checks = 0;

   // model: cycle number since reset release, plus buffer contents
   int          t;
   logic [15:0] act_m, shd_m;
   bit          pend_m;
   bit          armed = 1'b0;
   logic        fd_prev = 1'b0;

   display_scanner #(.NUM_DIGITS(N), .PRESCALE(P), .BLANK_CYCLES(B)) dut (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .din        (din),
      .digit_out  (digit_out),
      .anode_n    (anode_n),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (armed) begin
         checks++;
         assert (anode_n === 4'b1111 || $countones(~anode_n) == 1)
         else begin
            errors++;
            $error("FAIL onehot anode_n=%b required one-hot-low or 1111", anode_n);
         end
         checks++;
         assert (!(frame_done === 1'b1 && fd_prev === 1'b1))
         else begin
            errors++;
            $error("FAIL fd_width frame_done high 2 cycles, required 1");
         end
         fd_prev <= frame_done;
      end
   end

   task automatic check_model();
      int slot, pos;
      logic [3:0] e_an, e_dg;
      logic       e_fd;
      slot = (t / P) % N;
      pos  = t % P;
      e_an = (pos < B) ? 4'b1111 : ~(4'b0001 << slot);
      e_dg = 4'(act_m >> (4 * slot));
      e_fd = (t > 0) && (t % NP == 0);
      checks++;
      assert (anode_n === e_an) else begin
         errors++;
         $error("FAIL anode t=%0d got=%b exp=%b", t, anode_n, e_an);
      end
      checks++;
      assert (digit_out === e_dg) else begin
         errors++;
         $error("FAIL digit t=%0d got=%h exp=%h", t, digit_out, e_dg);
      end
      checks++;
      assert (frame_done === e_fd) else begin
         errors++;
         $error("FAIL frame_done t=%0d got=%b exp=%b", t, frame_done, e_fd);
      end
   endtask

   task automatic check_const(input string tag, input logic [3:0] e_an, input logic [3:0] e_dg);
      checks++;
      assert (anode_n === e_an && digit_out === e_dg) else begin
         errors++;
         $error("FAIL %s got an=%b dg=%h exp an=%b dg=%h", tag, anode_n, digit_out, e_an, e_dg);
      end
   endtask

   task automatic cyc(input logic ld, input logic [15:0] d);
      load = ld;
      din  = d;
      @(posedge clk);
      t++;
      if (t % NP == 0 && pend_m) begin
         act_m  = shd_m;
         pend_m = 1'b0;
      end
      if (ld) begin
         shd_m  = d;
         pend_m = 1'b1;
      end
      #1;
      load = 1'b0;
      check_model();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 16'h0);
   endtask

   task automatic wait_phase(input int p);
      for (int i = 0; i < NP && (t % NP) != p; i++) cyc(1'b0, 16'h0);
   endtask

   task automatic do_reset(input int n);
      rst  = 1'b1;
      load = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      t = 0; act_m = '0; shd_m = '0; pend_m = 1'b0;
      check_const("reset", 4'b1111, 4'h0);
      checks++;
      assert (frame_done === 1'b0) else begin
         errors++;
         $error("FAIL reset_fd got=%b exp=0", frame_done);
      end
      rst = 1'b0;
      check_model();
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; din = '0;
      t = 0; act_m = '0; shd_m = '0; pend_m = 1'b0;
      @(posedge clk);
      #1;

      // 1: reset then first slot timing
      do_reset(3);
      armed = 1'b1;
      idle(1);
      check_const("post_rst_blank", 4'b1111, 4'h0);
      idle(1);
      check_const("post_rst_show", 4'b1110, 4'h0);
      idle(4);

      // 2: load at frame start, shown next frame
      wait_phase(0);
      cyc(1'b1, 16'h1234);
      wait_phase(0);
      check_const("f1234_blank0", 4'b1111, 4'h4);
      wait_phase(2);
      check_const("f1234_slot0", 4'b1110, 4'h4);
      wait_phase(3 * P + 2);
      check_const("f1234_slot3", 4'b0111, 4'h1);
      wait_phase(0);

      // 3: load mid-frame during slot 2 SHOW
      wait_phase(2 * P + 3);
      cyc(1'b1, 16'h5678);
      wait_phase(3 * P + 3);
      check_const("old_slot3", 4'b0111, 4'h1);
      wait_phase(2);
      check_const("f5678_slot0", 4'b1110, 4'h8);
      wait_phase(0);

      // 4: last load in a frame wins
      wait_phase(1);
      cyc(1'b1, 16'hAAAA);
      wait_phase(10);
      cyc(1'b1, 16'h9009);
      wait_phase(P + 2);
      check_const("f9009_slot1", 4'b1101, 4'h0);
      wait_phase(0);

      // 5: load on the boundary edge itself
      wait_phase(NP - 1);
      cyc(1'b1, 16'h4321);
      wait_phase(2);
      check_const("boundary_old", 4'b1110, 4'h9);
      wait_phase(0);
      wait_phase(2);
      check_const("boundary_new", 4'b1110, 4'h1);
      wait_phase(0);

      // 6: reset mid slot-2 SHOW drops a pending load
      wait_phase(P + 1);
      cyc(1'b1, 16'hBEEF);
      wait_phase(2 * P + 3);
      do_reset(1);
      idle(2 * NP);

      // random loads with an interleaved random reset
      for (int i = 0; i < 6 * NP; i++)
         cyc(($urandom_range(0, 11) == 0), 16'($urandom));
      wait_phase($urandom_range(0, NP - 1));
      do_reset($urandom_range(1, 3));
      for (int i = 0; i < 4 * NP; i++)
         cyc(($urandom_range(0, 7) == 0), 16'($urandom));
      idle(2 * NP);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
